// File: rtl/alu_control_stage_if.sv
// rtl/alu_control_stage_if.sv - decode-in / ALU-op-out handshake bundle for alu_control_stage
interface alu_control_stage_if #(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 2,
  parameter int TAG_W    = 6
);
  logic                in_valid;
  logic                in_ready;
  logic [ALUOP_W-1:0]  alu_op_in;
  logic [OPCODE_W-1:0] opcode_in;
  logic [TAG_W-1:0]    tag_in;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          op_out;
  logic                illegal_out;
  logic [TAG_W-1:0]    tag_out;

  modport master (
    output in_valid, alu_op_in, opcode_in, tag_in, out_ready,
    input  in_ready, out_valid, op_out, illegal_out, tag_out
  );

  modport slave (
    input  in_valid, alu_op_in, opcode_in, tag_in, out_ready,
    output in_ready, out_valid, op_out, illegal_out, tag_out
  );
endinterface

// File: rtl/alu_control_stage.sv
// rtl/alu_control_stage.sv - registered ALU-control decode with 2-entry skid buffer and illegal-op count
// Optional LSL/LSR R-type decode is enabled by defining ALU_CTRL_SHIFT_EN.
module alu_control_stage #(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 2,
  parameter int TAG_W    = 6,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                err_clr,
  output logic [CNT_W-1:0]    err_count,
  alu_control_stage_if.slave  bus
);

  logic [10:0] opc;
  logic [3:0]  dec_op;
  logic        dec_ill;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [3:0]       skid_op_q, skid_op_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic accept;
  logic out_free;

  assign opc = bus.opcode_in[OPCODE_W-1 -: 11];

  always_comb begin
    dec_op  = 4'b1111;
    dec_ill = 1'b0;
    case (bus.alu_op_in[1:0])
      2'b00: dec_op = 4'b0010;
      2'b01: dec_op = 4'b0111;
      2'b10: begin
        case (opc)
          11'b10001011000: dec_op = 4'b0010;
          11'b11001011000: dec_op = 4'b0110;
          11'b10001010000: dec_op = 4'b0000;
          11'b10101010000: dec_op = 4'b0001;
`ifdef ALU_CTRL_SHIFT_EN
          11'b11010011011: dec_op = 4'b0011;
          11'b11010011010: dec_op = 4'b0100;
`endif
          default:         dec_ill = 1'b1;
        endcase
      end
      default: begin
        // I-type ignores opcode bit 0 (part of the immediate field)
        case (opc[10:1])
          10'b1001000100: dec_op = 4'b0010;
          10'b1101000100: dec_op = 4'b0110;
          10'b1001001000: dec_op = 4'b0000;
          10'b1011001000: dec_op = 4'b0001;
          default:        dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign accept   = bus.in_valid & in_ready_q & ~flush;
  assign out_free = ~out_valid_q | bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    op_d         = op_q;
    illegal_d    = illegal_q;
    tag_d        = tag_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so no accept can race this move
        out_valid_d  = 1'b1;
        op_d         = skid_op_q;
        illegal_d    = skid_ill_q;
        tag_d        = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        op_d        = dec_op;
        illegal_d   = dec_ill;
        tag_d       = bus.tag_in;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_op_d    = dec_op;
      skid_ill_d   = dec_ill;
      skid_tag_d   = bus.tag_in;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = (accept & dec_ill) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (accept & dec_ill & ~(&err_count_q)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      op_q         <= 4'b1111;
      illegal_q    <= 1'b0;
      tag_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= 4'b1111;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
      err_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      op_q         <= op_d;
      illegal_q    <= illegal_d;
      tag_q        <= tag_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.op_out      = op_q;
  assign bus.illegal_out = illegal_q;
  assign bus.tag_out     = tag_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_alu_control_stage.sv
// tb/tb_alu_control_stage.sv - directed self-checking bench for alu_control_stage
module tb_alu_control_stage;
  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       err_clr;
  logic [7:0] err_count;
  int         n_checks;
  int         n_fail;

  alu_control_stage_if #(.OPCODE_W(11), .ALUOP_W(2), .TAG_W(6)) bus ();

  alu_control_stage #(.OPCODE_W(11), .ALUOP_W(2), .TAG_W(6), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .err_clr   (err_clr),
    .err_count (err_count),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [10:0] o, input logic [5:0] t);
    bus.in_valid  = v;
    bus.alu_op_in = a;
    bus.opcode_in = o;
    bus.tag_in    = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.op_out !== 4'b1111) begin n_fail++; $display("FAIL reset_op got %b exp 1111", bus.op_out); end
    n_checks++; if (bus.illegal_out !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", bus.illegal_out); end
    n_checks++; if (bus.tag_out !== 6'd0) begin n_fail++; $display("FAIL reset_tag got %0d exp 0", bus.tag_out); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", err_count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    logic [1:0]  va [10];
    logic [10:0] vo [10];
    logic [3:0]  ve [10];
    va[0] = 2'b10; vo[0] = 11'b11001011000; ve[0] = 4'b0110;
    va[1] = 2'b11; vo[1] = 11'b10010010001; ve[1] = 4'b0000;
    va[2] = 2'b01; vo[2] = 11'b10101010101; ve[2] = 4'b0111;
    va[3] = 2'b00; vo[3] = 11'b11111111111; ve[3] = 4'b0010;
    va[4] = 2'b10; vo[4] = 11'b10001011000; ve[4] = 4'b0010;
    va[5] = 2'b10; vo[5] = 11'b10001010000; ve[5] = 4'b0000;
    va[6] = 2'b10; vo[6] = 11'b10101010000; ve[6] = 4'b0001;
    va[7] = 2'b11; vo[7] = 11'b10010001000; ve[7] = 4'b0010;
    va[8] = 2'b11; vo[8] = 11'b11010001001; ve[8] = 4'b0110;
    va[9] = 2'b11; vo[9] = 11'b10110010000; ve[9] = 4'b0001;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, va[i], vo[i], 6'(i + 5));
      step();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dec%0d_valid got %b exp 1", i, bus.out_valid); end
      n_checks++; if (bus.op_out !== ve[i]) begin n_fail++; $display("FAIL dec%0d_op got %b exp %b", i, bus.op_out, ve[i]); end
      n_checks++; if (bus.tag_out !== 6'(i + 5)) begin n_fail++; $display("FAIL dec%0d_tag got %0d exp %0d", i, bus.tag_out, i + 5); end
      n_checks++; if (bus.illegal_out !== 1'b0) begin n_fail++; $display("FAIL dec%0d_illegal got %b exp 0", i, bus.illegal_out); end
    end
    drive(1'b0, 2'b00, 11'd0, 6'd0);
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_idle_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL dec_err got %0d exp 0", err_count); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 11'd0, 6'd1);
    step();
    n_checks++; if (bus.tag_out !== 6'd1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first got v=%b tag=%0d exp v=1 tag=1", bus.out_valid, bus.tag_out); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b exp 1", bus.in_ready); end
    drive(1'b1, 2'b01, 11'd0, 6'd2);
    step();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b exp 0", bus.in_ready); end
    n_checks++; if (bus.tag_out !== 6'd1) begin n_fail++; $display("FAIL bp_hold1 got %0d exp 1", bus.tag_out); end
    drive(1'b1, 2'b00, 11'd0, 6'd3);
    step();
    n_checks++; if (bus.tag_out !== 6'd1 || bus.op_out !== 4'b0010) begin n_fail++; $display("FAIL bp_hold2 got tag=%0d op=%b exp tag=1 op=0010", bus.tag_out, bus.op_out); end
    drive(1'b0, 2'b00, 11'd0, 6'd0);
    bus.out_ready = 1'b1;
    step();
    n_checks++; if (bus.tag_out !== 6'd2 || bus.op_out !== 4'b0111 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second got v=%b tag=%0d op=%b exp v=1 tag=2 op=0111", bus.out_valid, bus.tag_out, bus.op_out); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b exp 1", bus.in_ready); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b exp 0 (tag 3 must not have entered)", bus.out_valid); end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 11'b11111111111, 6'd9);
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++; if (bus.illegal_out !== 1'b1 || bus.op_out !== 4'b1111) begin n_fail++; $display("FAIL ill%0d got ill=%b op=%b exp ill=1 op=1111", i, bus.illegal_out, bus.op_out); end
      n_checks++; if (err_count !== 8'(i)) begin n_fail++; $display("FAIL ill%0d_count got %0d exp %0d", i, err_count, i); end
    end
    err_clr = 1'b1;
    step();
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL ill_clr_accept got %0d exp 1", err_count); end
    drive(1'b0, 2'b00, 11'd0, 6'd0);
    step();
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL ill_clr got %0d exp 0", err_count); end
    err_clr = 1'b0;
  endtask

  task automatic test_saturate();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b11, 11'b00000000000, 6'd4);
    for (int i = 0; i < 260; i++) step();
    n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat got %0d exp 255", err_count); end
    drive(1'b0, 2'b00, 11'd0, 6'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL sat_clr got %0d exp 0", err_count); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 11'd0, 6'd7);
    step();
    drive(1'b1, 2'b00, 11'd0, 6'd8);
    step();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_full got %b exp 0", bus.in_ready); end
    drive(1'b1, 2'b10, 11'b11111111111, 6'd9);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL fl_err got %0d exp 0", err_count); end
    drive(1'b0, 2'b00, 11'd0, 6'd0);
    bus.out_ready = 1'b1;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_dropped got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_shift();
    logic [3:0] exp_lsl, exp_lsr;
    logic       exp_ill;
`ifdef ALU_CTRL_SHIFT_EN
    exp_lsl = 4'b0011; exp_lsr = 4'b0100; exp_ill = 1'b0;
`else
    exp_lsl = 4'b1111; exp_lsr = 4'b1111; exp_ill = 1'b1;
`endif
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 11'b11010011011, 6'd10);
    step();
    n_checks++; if (bus.op_out !== exp_lsl || bus.illegal_out !== exp_ill) begin n_fail++; $display("FAIL lsl got op=%b ill=%b exp op=%b ill=%b", bus.op_out, bus.illegal_out, exp_lsl, exp_ill); end
    drive(1'b1, 2'b10, 11'b11010011010, 6'd11);
    step();
    n_checks++; if (bus.op_out !== exp_lsr || bus.illegal_out !== exp_ill) begin n_fail++; $display("FAIL lsr got op=%b ill=%b exp op=%b ill=%b", bus.op_out, bus.illegal_out, exp_lsr, exp_ill); end
    n_checks++; if (err_count !== (exp_ill ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL shift_err got %0d exp %0d", err_count, exp_ill ? 2 : 0); end
    drive(1'b0, 2'b00, 11'd0, 6'd0);
    step();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 11'd0, 6'd12);
    step();
    drive(1'b1, 2'b00, 11'd0, 6'd13);
    step();
    drive(1'b0, 2'b00, 11'd0, 6'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready); end
    n_checks++; if (err_count !== 8'd0 || bus.tag_out !== 6'd0) begin n_fail++; $display("FAIL rst_mid_state got err=%0d tag=%0d exp 0 0", err_count, bus.tag_out); end
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after got %b exp 0", bus.out_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 2'b00, 11'd0, 6'd0);
    test_reset();
    test_decode();
    test_back_to_back();
    test_illegal();
    test_saturate();
    test_flush();
    test_shift();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
